// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants and types for the instruction fetch stage.
//   NOP_INSTR   : encoding loaded into IF/ID for a bubble
//   HALT_OPCODE : opcode field [31:26] that stops fetching
//   fetch_state_e : RUN / HALT state encoding of the fetch FSM
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic [5:0]  HALT_OPCODE = 6'h3f;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/if_id_register.sv
// -----------------------------------------------------------------------------
// if_id_register
// Pipeline register between fetch and decode.
// Ports:
//   i_clk, i_reset           : clock, synchronous active-high reset
//   i_hold                   : keep current contents
//   i_bubble                 : load NOP with valid=0 (wins over i_hold)
//   i_instr, i_pc_plus4      : values captured on a normal load
//   o_instr, o_pc_plus4,
//   o_valid                  : registered IF/ID contents
// -----------------------------------------------------------------------------
module if_id_register
    import fetch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_hold,
    input  logic        i_bubble,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc_plus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
        end else if (i_bubble) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
        end else if (!i_hold) begin
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule : if_id_register

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage: drives pc to instruction memory, captures the returned word
// into IF/ID one cycle later, handles stall, redirect, halt opcode and
// out-of-range fetch faults.
// Ports:
//   clk_e, reset       : clock, synchronous active-high reset
//   pc                 : fetch byte address
//   Instruction_Code   : combinational memory data for pc
//   stall              : hold pc and IF/ID
//   redirect,
//   redirect_target    : load a new word-aligned fetch address, flush IF/ID
//   if_id_instr,
//   if_id_pc_plus4,
//   if_id_valid        : IF/ID register outputs
//   halted             : FSM is in HALT
//   fault              : sticky out-of-range fetch flag
//   o_dbg_state        : current FSM state
// Control priority: reset > HALT > redirect > stall > range fault > advance.
// -----------------------------------------------------------------------------
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          IMEM_BYTES = 32,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic         clk_e,
    input  logic         reset,
    output logic [31:0]  pc,
    input  logic [31:0]  Instruction_Code,
    input  logic         stall,
    input  logic         redirect,
    input  logic [31:0]  redirect_target,
    output logic [31:0]  if_id_instr,
    output logic [31:0]  if_id_pc_plus4,
    output logic         if_id_valid,
    output logic         halted,
    output logic         fault,
    output fetch_state_e o_dbg_state
);

    // Highest address at which a full 32-bit word still fits in memory.
    localparam logic [31:0] LAST_WORD_ADDR = 32'(IMEM_BYTES - 4);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic         r_fault;

    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_redirect_pc;
    logic         w_out_of_range;
    logic         w_halt_word;
    logic         w_hold;
    logic         w_bubble;
    logic         w_unused;

    // Modulo 2^32 by construction of the 32-bit sum.
    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_redirect_pc  = {redirect_target[31:2], 2'b00};
    assign w_out_of_range = (r_pc > LAST_WORD_ADDR);
    assign w_halt_word    = (Instruction_Code[31:26] == HALT_OPCODE);
    // Low target bits are discarded by word alignment.
    assign w_unused       = ^redirect_target[1:0];

    always_comb begin
        w_hold   = 1'b0;
        w_bubble = 1'b0;
        if (r_state == ST_HALT) begin
            w_bubble = 1'b1;
        end else if (redirect) begin
            w_bubble = 1'b1;
        end else if (stall) begin
            w_hold = 1'b1;
        end else if (w_out_of_range) begin
            w_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk_e) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (redirect) begin
                        r_pc <= w_redirect_pc;
                    end else if (stall) begin
                        r_pc <= r_pc;
                    end else if (w_out_of_range) begin
                        // pc stays on the faulting address for debug.
                        r_fault <= 1'b1;
                        r_state <= ST_HALT;
                    end else begin
                        r_pc <= w_pc_plus4;
                        if (w_halt_word) begin
                            r_state <= ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    if_id_register u_if_id (
        .i_clk      (clk_e),
        .i_reset    (reset),
        .i_hold     (w_hold),
        .i_bubble   (w_bubble),
        .i_instr    (Instruction_Code),
        .i_pc_plus4 (w_pc_plus4),
        .o_instr    (if_id_instr),
        .o_pc_plus4 (if_id_pc_plus4),
        .o_valid    (if_id_valid)
    );

    assign pc          = r_pc;
    assign fault       = r_fault;
    assign halted      = (r_state == ST_HALT);
    assign o_dbg_state = r_state;

endmodule : instruction_fetch_unit

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] W0 = 32'h0123_4567;
    localparam logic [31:0] W1 = 32'h89AB_CDEF;
    localparam logic [31:0] W2 = 32'h1357_9BDF;
    localparam logic [31:0] W3 = 32'h2468_ACE0;

    logic         clk_e = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  pc;
    logic [31:0]  Instruction_Code;
    logic         stall = 1'b0;
    logic         redirect = 1'b0;
    logic [31:0]  redirect_target = 32'h0;
    logic [31:0]  if_id_instr;
    logic [31:0]  if_id_pc_plus4;
    logic         if_id_valid;
    logic         halted;
    logic         fault;
    fetch_state_e dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Byte-addressed instruction memory, big-endian words.
    logic [7:0] imem [0:31];

    // ---------------- clock / reset ----------------
    always #5 clk_e = ~clk_e;

    instruction_fetch_unit #(.IMEM_BYTES(32), .RESET_PC(32'h0)) dut (
        .clk_e            (clk_e),
        .reset            (reset),
        .pc               (pc),
        .Instruction_Code (Instruction_Code),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_target  (redirect_target),
        .if_id_instr      (if_id_instr),
        .if_id_pc_plus4   (if_id_pc_plus4),
        .if_id_valid      (if_id_valid),
        .halted           (halted),
        .fault            (fault),
        .o_dbg_state      (dbg_state)
    );

    always_comb begin
        if (pc <= 32'd28)
            Instruction_Code = {imem[pc[4:0]], imem[pc[4:0] + 5'd1],
                                imem[pc[4:0] + 5'd2], imem[pc[4:0] + 5'd3]};
        else
            Instruction_Code = 32'h0;
    end

    // ---------------- driver tasks ----------------
    task automatic load_word(input int addr, input logic [31:0] w);
        imem[addr]     = w[31:24];
        imem[addr + 1] = w[23:16];
        imem[addr + 2] = w[15:8];
        imem[addr + 3] = w[7:0];
    endtask

    // Inputs are set before calling; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_e);
        #1;
    endtask

    task automatic do_reset();
        stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc act=%h exp=%h", pc, 32'h0); end
        n_checks++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr act=%h exp=%h", if_id_instr, 32'h0); end
        n_checks++; if (if_id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 act=%h exp=%h", if_id_pc_plus4, 32'h0); end
        n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid act=%b exp=0", if_id_valid); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted act=%b exp=0", halted); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault act=%b exp=0", fault); end
        n_checks++; if (dbg_state !== ST_RUN) begin n_fail++; $display("FAIL reset_state act=%0d exp=%0d", dbg_state, ST_RUN); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_w [0:3];
        exp_w[0] = W0; exp_w[1] = W1; exp_w[2] = W2; exp_w[3] = W3;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++; if (if_id_instr !== exp_w[k-1]) begin n_fail++; $display("FAIL seq_instr%0d act=%h exp=%h", k, if_id_instr, exp_w[k-1]); end
            n_checks++; if (pc !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_pc%0d act=%h exp=%h", k, pc, 32'(4 * k)); end
            n_checks++; if (if_id_pc_plus4 !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_pc4_%0d act=%h exp=%h", k, if_id_pc_plus4, 32'(4 * k)); end
            n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d act=%b exp=1", k, if_id_valid); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        tick();
        n_checks++; if (pc !== 32'd8) begin n_fail++; $display("FAIL stall_pre_pc act=%h exp=%h", pc, 32'd8); end
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++; if (pc !== 32'd8) begin n_fail++; $display("FAIL stall_pc%0d act=%h exp=%h", k, pc, 32'd8); end
            n_checks++; if (if_id_instr !== W1) begin n_fail++; $display("FAIL stall_instr%0d act=%h exp=%h", k, if_id_instr, W1); end
            n_checks++; if (if_id_pc_plus4 !== 32'd8) begin n_fail++; $display("FAIL stall_pc4_%0d act=%h exp=%h", k, if_id_pc_plus4, 32'd8); end
            n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid%0d act=%b exp=1", k, if_id_valid); end
        end
        stall = 1'b0;
        tick();
        n_checks++; if (if_id_instr !== W2) begin n_fail++; $display("FAIL stall_rel_instr act=%h exp=%h", if_id_instr, W2); end
        n_checks++; if (if_id_pc_plus4 !== 32'd12) begin n_fail++; $display("FAIL stall_rel_pc4 act=%h exp=%h", if_id_pc_plus4, 32'd12); end
        n_checks++; if (pc !== 32'd12) begin n_fail++; $display("FAIL stall_rel_pc act=%h exp=%h", pc, 32'd12); end
    endtask

    // Continues from test_stall with pc=12.
    task automatic test_redirect_over_stall();
        stall = 1'b1; redirect = 1'b1; redirect_target = 32'h13;
        tick();
        n_checks++; if (pc !== 32'd16) begin n_fail++; $display("FAIL redir_pc act=%h exp=%h", pc, 32'd16); end
        n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid act=%b exp=0", if_id_valid); end
        n_checks++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL redir_instr act=%h exp=%h", if_id_instr, 32'h0); end
        stall = 1'b0; redirect = 1'b0;
        tick();
        n_checks++; if (pc !== 32'd20) begin n_fail++; $display("FAIL redir_next_pc act=%h exp=%h", pc, 32'd20); end
        n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL redir_next_valid act=%b exp=1", if_id_valid); end
        n_checks++; if (if_id_pc_plus4 !== 32'd20) begin n_fail++; $display("FAIL redir_next_pc4 act=%h exp=%h", if_id_pc_plus4, 32'd20); end
    endtask

    task automatic test_halt_opcode();
        load_word(4, 32'hFC00_0000);
        do_reset();
        tick();
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_pre act=%b exp=0", halted); end
        tick();
        n_checks++; if (if_id_instr !== 32'hFC00_0000) begin n_fail++; $display("FAIL halt_instr act=%h exp=%h", if_id_instr, 32'hFC00_0000); end
        n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL halt_instr_valid act=%b exp=1", if_id_valid); end
        n_checks++; if (pc !== 32'd8) begin n_fail++; $display("FAIL halt_pc act=%h exp=%h", pc, 32'd8); end
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag act=%b exp=1", halted); end
        redirect = 1'b1; redirect_target = 32'h0; stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++; if (pc !== 32'd8) begin n_fail++; $display("FAIL halt_frozen_pc%0d act=%h exp=%h", k, pc, 32'd8); end
            n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid%0d act=%b exp=0", k, if_id_valid); end
            n_checks++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL halt_nop%0d act=%h exp=%h", k, if_id_instr, 32'h0); end
            n_checks++; if (dbg_state !== ST_HALT) begin n_fail++; $display("FAIL halt_state%0d act=%0d exp=%0d", k, dbg_state, ST_HALT); end
            stall = 1'b0;
        end
        redirect = 1'b0;
        load_word(4, W1);
    endtask

    task automatic test_fault_end_of_mem();
        do_reset();
        for (int k = 0; k < 8; k++) tick();
        n_checks++; if (pc !== 32'd32) begin n_fail++; $display("FAIL end_pc act=%h exp=%h", pc, 32'd32); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL end_fault_early act=%b exp=0", fault); end
        n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL end_last_valid act=%b exp=1", if_id_valid); end
        tick();
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL end_fault act=%b exp=1", fault); end
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL end_halted act=%b exp=1", halted); end
        n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL end_valid act=%b exp=0", if_id_valid); end
        n_checks++; if (pc !== 32'd32) begin n_fail++; $display("FAIL end_pc_frozen act=%h exp=%h", pc, 32'd32); end
    endtask

    // Continues from test_fault_end_of_mem with halted=1, fault=1.
    task automatic test_reset_from_halt();
        reset = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_target = 32'h40;
        tick();
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_halt_pc act=%h exp=%h", pc, 32'h0); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halt_halted act=%b exp=0", halted); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL rst_halt_fault act=%b exp=0", fault); end
        n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_halt_valid act=%b exp=0", if_id_valid); end
        reset = 1'b0; stall = 1'b0; redirect = 1'b0;
        tick();
        n_checks++; if (if_id_instr !== W0) begin n_fail++; $display("FAIL rst_resume_instr act=%h exp=%h", if_id_instr, W0); end
        n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL rst_resume_valid act=%b exp=1", if_id_valid); end
        n_checks++; if (pc !== 32'd4) begin n_fail++; $display("FAIL rst_resume_pc act=%h exp=%h", pc, 32'd4); end
    endtask

    task automatic test_redirect_out_of_range();
        do_reset();
        redirect = 1'b1; redirect_target = 32'hFFFF_FFFF;
        tick();
        n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL oor_pc act=%h exp=%h", pc, 32'hFFFF_FFFC); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL oor_fault_early act=%b exp=0", fault); end
        redirect = 1'b0;
        tick();
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL oor_fault act=%b exp=1", fault); end
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL oor_halted act=%b exp=1", halted); end
        n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL oor_valid act=%b exp=0", if_id_valid); end
        n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL oor_pc_frozen act=%h exp=%h", pc, 32'hFFFF_FFFC); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 32; i++) imem[i] = 8'h00;
        load_word(0, W0);
        load_word(4, W1);
        load_word(8, W2);
        load_word(12, W3);

        test_reset();
        test_sequential();
        test_stall();
        test_redirect_over_stall();
        test_halt_opcode();
        test_fault_end_of_mem();
        test_reset_from_halt();
        test_redirect_out_of_range();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_instruction_fetch_unit

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter IMEM_BYTES, default 32, meaning the instruction memory size in bytes.
REQ-002 SHALL have parameter RESET_PC, default 32'h0, meaning the first fetch address after reset.
REQ-003 SHALL have port clk_e, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port pc, output, 32 bits: fetch byte address driven to instruction memory.
REQ-006 SHALL have port Instruction_Code, input, 32 bits: memory read data for pc, combinational in the same cycle, big-endian byte order.
REQ-007 SHALL have port stall, input, 1 bit: hold pc and IF/ID contents.
REQ-008 SHALL have port redirect, input, 1 bit: taken branch/jump; load redirect_target.
REQ-009 SHALL have port redirect_target, input, 32 bits: new fetch address.
REQ-010 SHALL have port if_id_instr, output, 32 bits: registered instruction to decode.
REQ-011 SHALL have port if_id_pc_plus4, output, 32 bits: registered fetch address + 4.
REQ-012 SHALL have port if_id_valid, output, 1 bit: if_id_instr is a real instruction, not a bubble.
REQ-013 SHALL have port halted, output, 1 bit: unit is in HALT.
REQ-014 SHALL have port fault, output, 1 bit: sticky, set on an out-of-range fetch.

Function
REQ-015 SHALL implement FSM states RUN and HALT; reset enters RUN.
REQ-016 In RUN with no stall or redirect, SHALL capture Instruction_Code, pc+4 and valid=1 into IF/ID and set pc <= pc+4 each cycle.
REQ-017 Latency SHALL be 1 cycle: the word at pc in cycle N appears on if_id_instr in cycle N+1.
REQ-018 Event priority SHALL be reset > redirect > stall > normal advance.
REQ-019 On redirect, SHALL set pc <= {redirect_target[31:2],2'b00} and load IF/ID with NOP 32'h0, valid=0, regardless of stall.
REQ-020 On stall without redirect, SHALL hold pc and all IF/ID outputs unchanged.
REQ-021 If the fetched word has opcode bits [31:26]==6'h3f and is being captured, SHALL pass it to IF/ID with valid=1, then enter HALT.
REQ-022 In HALT, SHALL freeze pc, drive IF/ID NOP with valid=0, assert halted=1 and ignore stall and redirect; HALT SHALL exit only on reset.
REQ-023 If pc > IMEM_BYTES-4 in RUN, SHALL not capture the word, SHALL load IF/ID with a NOP bubble, set fault=1, and enter HALT.
REQ-024 pc+4 arithmetic SHALL be 32-bit modulo 2^32; wrap to 0 then triggers the REQ-023 range check normally.
REQ-025 Out-of-range redirect_target SHALL be accepted into pc and faulted on the following cycle per REQ-023.

Reset
REQ-026 When reset=1 at a rising clk_e, SHALL set pc=RESET_PC, if_id_instr=32'h0, if_id_pc_plus4=32'h0, if_id_valid=0, halted=0, fault=0, state=RUN.
REQ-027 Reset SHALL override any concurrent stall, redirect or HALT, including mid-stall and mid-halt.

Structure
REQ-028 SHALL place NOP_INSTR (32'h0), HALT_OPCODE (6'h3f) and the RUN/HALT state encoding in a shared package, fetch_pkg.
REQ-029 SHALL instantiate one sub-module, if_id_register, holding instr/pc_plus4/valid with hold and bubble controls.

Verification
REQ-030 Bench SHALL cover sequential fetch: memory words W0..W3 at 0,4,8,12, no stall -> if_id_instr = W0..W3 on cycles 1..4, pc = 4,8,12,16, if_id_pc_plus4 = 4,8,12,16.
REQ-031 Bench SHALL cover a 2-cycle stall at pc=8 -> pc stays 8, IF/ID holds W1/8 for 2 cycles, then W2 captured.
REQ-032 Bench SHALL cover redirect=1 with target 32'h13 while stall=1 -> next pc=16, if_id_valid=0, if_id_instr=0.
REQ-033 Bench SHALL cover word 32'hFC00_0000 at pc=4 -> it appears valid at IF/ID, then halted=1, pc frozen at 8, valid=0 thereafter despite redirect.
REQ-034 Bench SHALL cover sequential fetch reaching pc=32 with IMEM_BYTES=32 -> fault=1, halted=1, if_id_valid=0.
REQ-035 Bench SHALL cover reset asserted in HALT with fault=1 -> the next cycle shows pc=0, halted=0, fault=0, and fetch resumes.
